// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: memory-access FSM encoding and default memory timeout.
package riscv_pkg;

  typedef enum logic {
    MaIdle = 1'b0,
    MaWait = 1'b1
  } ma_state_e;

  localparam int unsigned MaTimeoutCycles = 15;

endpackage

// File: rtl/ma_mem_ctrl.sv
// Data-memory request FSM: issues one request per memory op, waits for ack or timeout.
module ma_mem_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = MaTimeoutCycles
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        start_we,
  input  logic [31:0] start_addr,
  input  logic [31:0] start_wdata,
  input  logic        mem_ack,
  output logic        ma_stall,
  output logic        done_ok,
  output logic        done_to,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  ma_state_e       state_q;
  logic [CntW-1:0] cnt_q;

  assign ma_stall = (state_q == MaWait);
  assign done_ok  = ma_stall & mem_ack;
  // An ack landing on the final wait cycle wins over the timeout.
  assign done_to  = ma_stall & ~mem_ack & (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MaIdle;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      unique case (state_q)
        MaIdle: begin
          if (start) begin
            state_q   <= MaWait;
            cnt_q     <= '0;
            mem_req   <= 1'b1;
            mem_we    <= start_we;
            mem_addr  <= start_addr;
            mem_wdata <= start_wdata;
          end
        end
        MaWait: begin
          if (mem_ack || cnt_q == CntLast) begin
            state_q <= MaIdle;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_ack) mem_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= MaIdle;
      endcase
    end
  end

endmodule

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: holds the MA/RW register and muxes retire data from
// the pass-through path or the completed memory access.
module ma_stage
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = MaTimeoutCycles
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_ma_valid,
  input  logic [31:0] ex_ma_pc,
  input  logic [31:0] ex_ma_inst,
  input  logic [31:0] ex_ma_aluresult,
  input  logic [31:0] ex_ma_op2,
  input  logic        ex_ma_isld,
  input  logic        ex_ma_isst,
  input  logic        ex_ma_iscall,
  input  logic        ex_ma_iswb,
  output logic        ma_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ma_rw_valid,
  output logic        ma_rw_isld,
  output logic        ma_rw_iscall,
  output logic        ma_rw_iswb,
  output logic [31:0] ma_rw_pc,
  output logic [31:0] ma_rw_inst,
  output logic [31:0] ma_rw_aluresult,
  output logic [31:0] ma_rw_ldresult,
  output logic        mem_err
);

  logic mem_op, start, done_ok, done_to;

  assign mem_op = ex_ma_isld | ex_ma_isst;
  assign start  = ~ma_stall & ex_ma_valid & mem_op;

  ma_mem_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_we   (ex_ma_isst & ~ex_ma_isld),
    .start_addr (ex_ma_aluresult),
    .start_wdata(ex_ma_op2),
    .mem_ack    (mem_ack),
    .ma_stall   (ma_stall),
    .done_ok    (done_ok),
    .done_to    (done_to),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_err    (mem_err)
  );

  // Instruction captured at acceptance; the EX/MA inputs are not trusted during WAIT.
  logic [31:0] lat_pc_q, lat_inst_q, lat_alu_q;
  logic        lat_isld_q, lat_iscall_q, lat_iswb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_pc_q     <= '0;
      lat_inst_q   <= '0;
      lat_alu_q    <= '0;
      lat_isld_q   <= 1'b0;
      lat_iscall_q <= 1'b0;
      lat_iswb_q   <= 1'b0;
    end else if (start) begin
      lat_pc_q     <= ex_ma_pc;
      lat_inst_q   <= ex_ma_inst;
      lat_alu_q    <= ex_ma_aluresult;
      lat_isld_q   <= ex_ma_isld;
      lat_iscall_q <= ex_ma_iscall;
      lat_iswb_q   <= ex_ma_iswb;
    end
  end

  logic        valid_d, isld_d, iscall_d, iswb_d;
  logic [31:0] pc_d, inst_d, alu_d, ld_d;

  always_comb begin
    valid_d  = 1'b0;
    isld_d   = 1'b0;
    iscall_d = 1'b0;
    iswb_d   = 1'b0;
    pc_d     = ma_rw_pc;
    inst_d   = ma_rw_inst;
    alu_d    = ma_rw_aluresult;
    ld_d     = ma_rw_ldresult;
    if (ma_stall) begin
      if (done_ok || done_to) begin
        valid_d  = 1'b1;
        isld_d   = lat_isld_q;
        iscall_d = lat_iscall_q;
        // Stores and timed-out loads never write back.
        iswb_d   = done_ok & lat_isld_q & lat_iswb_q;
        pc_d     = lat_pc_q;
        inst_d   = lat_inst_q;
        alu_d    = lat_alu_q;
        ld_d     = (done_ok && lat_isld_q) ? mem_rdata : 32'h0;
      end
    end else if (ex_ma_valid && !mem_op) begin
      valid_d  = 1'b1;
      iscall_d = ex_ma_iscall;
      iswb_d   = ex_ma_iswb;
      pc_d     = ex_ma_pc;
      inst_d   = ex_ma_inst;
      alu_d    = ex_ma_aluresult;
      ld_d     = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_rw_valid     <= 1'b0;
      ma_rw_isld      <= 1'b0;
      ma_rw_iscall    <= 1'b0;
      ma_rw_iswb      <= 1'b0;
      ma_rw_pc        <= '0;
      ma_rw_inst      <= '0;
      ma_rw_aluresult <= '0;
      ma_rw_ldresult  <= '0;
    end else begin
      ma_rw_valid     <= valid_d;
      ma_rw_isld      <= isld_d;
      ma_rw_iscall    <= iscall_d;
      ma_rw_iswb      <= iswb_d;
      ma_rw_pc        <= pc_d;
      ma_rw_inst      <= inst_d;
      ma_rw_aluresult <= alu_d;
      ma_rw_ldresult  <= ld_d;
    end
  end

endmodule

// File: tb/tb_ma_stage.sv
// Directed bench for ma_stage: table of single-cycle vectors plus memory-access sequences.
module tb_ma_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_ma_valid, ex_ma_isld, ex_ma_isst, ex_ma_iscall, ex_ma_iswb;
  logic [31:0] ex_ma_pc, ex_ma_inst, ex_ma_aluresult, ex_ma_op2;
  logic        ma_stall, mem_req, mem_we, mem_ack, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        ma_rw_valid, ma_rw_isld, ma_rw_iscall, ma_rw_iswb;
  logic [31:0] ma_rw_pc, ma_rw_inst, ma_rw_aluresult, ma_rw_ldresult;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ma_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_ma_valid    (ex_ma_valid),
    .ex_ma_pc       (ex_ma_pc),
    .ex_ma_inst     (ex_ma_inst),
    .ex_ma_aluresult(ex_ma_aluresult),
    .ex_ma_op2      (ex_ma_op2),
    .ex_ma_isld     (ex_ma_isld),
    .ex_ma_isst     (ex_ma_isst),
    .ex_ma_iscall   (ex_ma_iscall),
    .ex_ma_iswb     (ex_ma_iswb),
    .ma_stall       (ma_stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .ma_rw_valid    (ma_rw_valid),
    .ma_rw_isld     (ma_rw_isld),
    .ma_rw_iscall   (ma_rw_iscall),
    .ma_rw_iswb     (ma_rw_iswb),
    .ma_rw_pc       (ma_rw_pc),
    .ma_rw_inst     (ma_rw_inst),
    .ma_rw_aluresult(ma_rw_aluresult),
    .ma_rw_ldresult (ma_rw_ldresult),
    .mem_err        (mem_err)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, inst, alu;
    logic        iscall, iswb, ack;
    logic [31:0] rdata;
    logic        e_valid;
    logic [31:0] e_pc, e_inst, e_alu;
    logic        e_iscall, e_iswb;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_ma_valid = 0; ex_ma_isld = 0; ex_ma_isst = 0; ex_ma_iscall = 0; ex_ma_iswb = 0;
    ex_ma_pc = 0; ex_ma_inst = 0; ex_ma_aluresult = 0; ex_ma_op2 = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic apply_vec(input string nm, input vec_t v);
    @(negedge clk);
    idle_inputs();
    ex_ma_valid = v.valid; ex_ma_pc = v.pc; ex_ma_inst = v.inst; ex_ma_aluresult = v.alu;
    ex_ma_iscall = v.iscall; ex_ma_iswb = v.iswb; mem_ack = v.ack; mem_rdata = v.rdata;
    @(posedge clk);
    @(negedge clk);
    chk({nm, ".valid"}, 32'(ma_rw_valid), 32'(v.e_valid));
    chk({nm, ".pc"}, ma_rw_pc, v.e_pc);
    chk({nm, ".inst"}, ma_rw_inst, v.e_inst);
    chk({nm, ".alu"}, ma_rw_aluresult, v.e_alu);
    chk({nm, ".iscall"}, 32'(ma_rw_iscall), 32'(v.e_iscall));
    chk({nm, ".iswb"}, 32'(ma_rw_iswb), 32'(v.e_iswb));
    chk({nm, ".isld"}, 32'(ma_rw_isld), 32'h0);
    chk({nm, ".mem_req"}, 32'(mem_req), 32'h0);
    chk({nm, ".stall"}, 32'(ma_stall), 32'h0);
    idle_inputs();
  endtask

  // ack_at: wait cycle on which mem_ack is driven; 0 means never (timeout after 15).
  task automatic mem_seq(input string nm, input logic ld, input logic st, input logic [31:0] pc,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_at, input logic exp_err);
    int n;
    logic        e_we, e_iswb;
    logic [31:0] e_ld;
    e_we   = st & ~ld;
    e_iswb = (ack_at != 0) & ld;
    e_ld   = (ack_at != 0 && ld) ? rdata : 32'h0;
    @(negedge clk);
    idle_inputs();
    ex_ma_valid = 1; ex_ma_isld = ld; ex_ma_isst = st; ex_ma_iswb = 1;
    ex_ma_pc = pc; ex_ma_inst = 32'h0000_2003; ex_ma_aluresult = addr; ex_ma_op2 = wdata;
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      mem_ack = 0;
      // Junk upstream contents while stalled must be ignored.
      ex_ma_valid = mem_req; ex_ma_isld = 0; ex_ma_isst = 0; ex_ma_iscall = 1;
      ex_ma_pc = 32'hBAD0_0000; ex_ma_aluresult = 32'hFFFF_0000; ex_ma_op2 = 32'h0BAD_0BAD;
      if (!mem_req) break;
      n++;
      chk({nm, ".addr"}, mem_addr, addr);
      chk({nm, ".we"}, 32'(mem_we), 32'(e_we));
      if (e_we) chk({nm, ".wdata"}, mem_wdata, wdata);
      chk({nm, ".stall"}, 32'(ma_stall), 32'h1);
      chk({nm, ".wait_valid"}, 32'(ma_rw_valid), 32'h0);
      if (n == ack_at) begin
        mem_ack = 1; mem_rdata = rdata;
      end
    end
    ex_ma_valid = 0;
    chk({nm, ".req_cycles"}, 32'(n), (ack_at != 0) ? 32'(ack_at) : 32'd15);
    chk({nm, ".rt_valid"}, 32'(ma_rw_valid), 32'h1);
    chk({nm, ".rt_pc"}, ma_rw_pc, pc);
    chk({nm, ".rt_alu"}, ma_rw_aluresult, addr);
    chk({nm, ".rt_isld"}, 32'(ma_rw_isld), 32'(ld));
    chk({nm, ".rt_iscall"}, 32'(ma_rw_iscall), 32'h0);
    chk({nm, ".rt_iswb"}, 32'(ma_rw_iswb), 32'(e_iswb));
    chk({nm, ".rt_ld"}, ma_rw_ldresult, e_ld);
    chk({nm, ".rt_stall"}, 32'(ma_stall), 32'h0);
    chk({nm, ".mem_err"}, 32'(mem_err), 32'(exp_err));
    idle_inputs();
  endtask

  initial begin
    vecs[0] = '{1, 32'h4, 32'h13, 32'hA5A5A5A5, 0, 1, 0, 32'h0,
                1, 32'h4, 32'h13, 32'hA5A5A5A5, 0, 1};
    vecs[1] = '{1, 32'h10, 32'h6F, 32'h14, 1, 1, 0, 32'h0,
                1, 32'h10, 32'h6F, 32'h14, 1, 1};
    vecs[2] = '{0, 32'h99, 32'h77, 32'h77, 1, 1, 1, 32'hCAFEF00D,
                0, 32'h10, 32'h6F, 32'h14, 0, 0};
    vecs[3] = '{1, 32'h20, 32'h33, 32'hDEADBEEF, 0, 0, 0, 32'h0,
                1, 32'h20, 32'h33, 32'hDEADBEEF, 0, 0};

    idle_inputs();
    rst_n = 0;
    #1;
    chk("rst.valid", 32'(ma_rw_valid), 32'h0);
    chk("rst.req", 32'(mem_req), 32'h0);
    chk("rst.stall", 32'(ma_stall), 32'h0);
    chk("rst.err", 32'(mem_err), 32'h0);
    chk("rst.pc", ma_rw_pc, 32'h0);
    chk("rst.alu", ma_rw_aluresult, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 4; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    mem_seq("load3", 1, 0, 32'h40, 32'h100, 32'h0, 32'h5A5A5A5A, 3, 0);
    mem_seq("store1", 0, 1, 32'h44, 32'h200, 32'h12345678, 32'h0, 1, 0);
    mem_seq("ldst2", 1, 1, 32'h48, 32'h300, 32'h55, 32'h0BADF00D, 2, 0);
    mem_seq("timeout", 1, 0, 32'h4C, 32'h400, 32'h0, 32'h0, 0, 1);
    apply_vec("alu_after_to", vecs[0]);
    chk("alu_after_to.err", 32'(mem_err), 32'h1);

    // Reset in the middle of a wait: access abandoned, no retire.
    @(negedge clk);
    ex_ma_valid = 1; ex_ma_isld = 1; ex_ma_aluresult = 32'h500; ex_ma_pc = 32'h50;
    @(posedge clk);
    @(negedge clk);
    ex_ma_valid = 0;
    chk("midrst.pre_req", 32'(mem_req), 32'h1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst.req", 32'(mem_req), 32'h0);
    chk("midrst.stall", 32'(ma_stall), 32'h0);
    chk("midrst.err", 32'(mem_err), 32'h0);
    chk("midrst.valid", 32'(ma_rw_valid), 32'h0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst.no_retire%0d", i), 32'(ma_rw_valid), 32'h0);
    end
    mem_seq("load_after_rst", 1, 0, 32'h60, 32'h100, 32'h0, 32'h5A5A5A5A, 3, 0);
    mem_seq("ack_at_limit", 1, 0, 32'h64, 32'h600, 32'h0, 32'h13572468, 15, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ma_stage.md
MA_STAGE -- requirements
Module: ma_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum WAIT cycles without mem_ack before abort.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ex_ma_valid  input  1  EX/MA register holds a live instruction.
REQ-005 ex_ma_pc, ex_ma_inst, ex_ma_aluresult, ex_ma_op2  input  32 each  pc, instruction word, ALU result or address, store data.
REQ-006 ex_ma_isld, ex_ma_isst, ex_ma_iscall, ex_ma_iswb  input  1 each  load, store, call and writeback flags.
REQ-007 ma_stall  output  1  upstream holds its EX/MA register while high.
REQ-008 mem_req, mem_we  output  1 each  data-memory request; write enable.
REQ-009 mem_addr, mem_wdata  output  32 each  memory address and store data.
REQ-010 mem_ack  input  1; mem_rdata  input  32  memory completion and load data.
REQ-011 ma_rw_valid, ma_rw_isld, ma_rw_iscall, ma_rw_iswb  output  1 each  MA/RW register to the RW stage.
REQ-012 ma_rw_pc, ma_rw_inst, ma_rw_aluresult, ma_rw_ldresult  output  32 each  MA/RW data fields.
REQ-013 mem_err  output  1  sticky memory-timeout flag.

Function
REQ-014 FSM states SHALL be IDLE and WAIT; ma_stall SHALL equal (state==WAIT), decoded from state only.
REQ-015 In IDLE with ex_ma_valid=1 and isld=isst=0, the instruction SHALL retire on the next edge: ma_rw_valid=1, with all fields and flags copied.
REQ-016 In IDLE with ex_ma_valid=1 and (isld|isst)=1, the block SHALL latch the instruction and go to WAIT; from the next cycle, mem_req=1, mem_addr=aluresult, mem_wdata=op2, mem_we=isst&~isld.
REQ-017 isld and isst asserted together SHALL be treated as a load.
REQ-018 In WAIT, mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable until mem_ack or timeout.
REQ-019 mem_ack in WAIT: on that edge mem_req SHALL drop, state SHALL go to IDLE, and the instruction SHALL retire with ma_rw_ldresult=mem_rdata for a load.
REQ-020 Load latency SHALL be (cycles to ack)+1 after acceptance; non-memory latency SHALL be 1 cycle.
REQ-021 Stores SHALL retire with ma_rw_iswb=0 regardless of ex_ma_iswb.
REQ-022 A WAIT cycle counter reaching TIMEOUT_CYCLES without ack SHALL: drop mem_req, set mem_err, retire with ma_rw_iswb=0 and ldresult=0, return to IDLE.
REQ-023 mem_ack and mem_rdata SHALL be ignored in IDLE.
REQ-024 mem_ack arriving in the same cycle as the timeout SHALL count as success; mem_err SHALL stay unchanged.
REQ-025 With no instruction retiring, ma_rw_valid, ma_rw_iswb, ma_rw_isld and ma_rw_iscall SHALL be 0 (bubble); the 32-bit fields SHALL hold.
REQ-026 ex_ma_* SHALL be ignored while in WAIT; the upstream stage holds it under ma_stall.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, the counter to 0, mem_req=0, mem_we=0, mem_err=0, and all ma_rw_* flags and 32-bit outputs to 0.
REQ-028 Reset during WAIT SHALL abandon the access without a retire; the first accept SHALL be on the first posedge after rst_n rises.

Structure
REQ-029 State encoding and the TIMEOUT_CYCLES default SHALL live in the shared pipeline package riscv_pkg.
REQ-030 The request/timeout FSM SHALL be a single sub-module, ma_mem_ctrl; ma_stage SHALL hold the MA/RW register and muxing.

Verification
REQ-031 ALU op: aluresult=0xA5A5A5A5, iswb=1 -> next cycle ma_rw_valid=1, aluresult=0xA5A5A5A5, ma_stall never high.
REQ-032 Load at 0x100, ack after 3 cycles with rdata=0x5A5A5A5A -> mem_req high for 3 cycles with addr stable, ma_stall high for 3 cycles, ldresult=0x5A5A5A5A, isld=1 one cycle after ack.
REQ-033 Store: op2=0x12345678, ack after 1 cycle -> mem_we=1, wdata=0x12345678, retire with iswb=0.
REQ-034 Call at pc=0x10, iscall=1 -> retire in 1 cycle with pc=0x10 and iscall=1, with no memory request.
REQ-035 Load with no ack -> mem_req drops after 15 cycles, mem_err=1 (sticky), retire with iswb=0; the next ALU op then completes normally.
REQ-036 rst_n pulsed low mid-WAIT -> mem_req=0 immediately, no ma_rw_valid pulse; a load issued after reset behaves as in REQ-032.
